fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 32 +++
 rtl/fetch_stage_if.sv | 11 +
 rtl/fetch_stage_if_id_reg.sv | 49 ++++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: constants and types shared by the IF stage and the
// instruction memory.
//   PC_RESET_DEF  : boot PC and base of the instruction window
//   NOP           : sll $0,$0,0, used for bubbles and faulted fetches
//   IMEM_ADR_BITS : word-address width of the instruction memory
//   if_id_t       : IF/ID pipeline register payload
//   ifid_op_e     : per-edge action of the IF/ID register
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP           = 32'h0000_0000;
  localparam int unsigned IMEM_ADR_BITS = 12;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        fault;
  } if_id_t;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_e;

  // Byte size of the instruction window for a given word-address width.
  function automatic logic [31:0] imem_win_bytes(input int unsigned adr_bits);
    return 32'd4 << adr_bits;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory fetch bus.
//   pc_f    : fetch address, driven by the IF stage
//   instr_f : word returned by the instruction memory for pc_f (same cycle)
// master = IF stage, slave = instruction memory.
interface fetch_stage_if;
  logic [31:0] pc_f;
  logic [31:0] instr_f;

  modport master (output pc_f, input  instr_f);
  modport slave  (input  pc_f, output instr_f);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// fetch_stage_if_id_reg: IF/ID pipeline register plus the count of
// instructions accepted into it.
//   clk, reset : clock, synchronous active-high reset
//   op         : hold / load / bubble for this edge
//   ld         : payload captured on a load
//   q          : registered IF/ID payload
//   fetch_cnt  : number of loads since reset (wraps at 2^32)
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  ifid_op_e    op,
  input  if_id_t      ld,
  output if_id_t      q,
  output logic [31:0] fetch_cnt
);

  if_id_t      ifid_q, ifid_d;
  logic [31:0] cnt_q,  cnt_d;

  always_comb begin
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    case (op)
      IFID_LOAD: begin
        ifid_d = ld;
        cnt_d  = cnt_q + 32'd1;
      end
      // Bubbles are not counted: nothing was accepted.
      IFID_BUBBLE: ifid_d = '{instr: NOP, pc: '0, pc8: '0, fault: 1'b0};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q <= '{instr: NOP, pc: '0, pc8: '0, fault: 1'b0};
      cnt_q  <= '0;
    end else begin
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q         = ifid_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the pipelined MIPS core. Owns the PC, drives the
// fetch address on the imem bus and registers the returned word into IF/ID.
//   clk, reset         : clock, synchronous active-high reset
//   stall              : hold PC and IF/ID (also masks redirect)
//   flush              : IF/ID becomes a bubble next edge, even under stall
//   redirect, npc      : taken branch/jump target resolved in ID
//   imem (master)      : pc_f out, instr_f in
//   instr_d/pc_d/pc8_d : IF/ID instruction, PC, PC+8 link value
//   fault_d            : IF/ID fetch fault (misaligned / outside window)
//   fetch_cnt          : instructions accepted into IF/ID (debug)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
  parameter int unsigned ADR_BITS   = IMEM_ADR_BITS,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [31:0]        npc,
  fetch_stage_if.master      imem,
  output logic [31:0]        instr_d,
  output logic [31:0]        pc_d,
  output logic [31:0]        pc8_d,
  output logic               fault_d,
  output logic [31:0]        fetch_cnt
);

  // Exclusive end of the instruction window, 32-bit unsigned, no wrap slack.
  localparam logic [31:0] WIN_END = PC_RESET + imem_win_bytes(ADR_BITS);

  logic [31:0] pcf_q, pcf_d;
  logic        fault_f;
  ifid_op_e    ifid_op;
  if_id_t      ifid_ld, ifid;

  // PC: stall > redirect > sequential. A redirect seen under stall is
  // dropped; ID holds it and re-asserts once the stall releases.
  always_comb begin
    pcf_d = pcf_q;
    if (!stall) pcf_d = redirect ? npc : pcf_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) pcf_q <= PC_RESET;
    else       pcf_q <= pcf_d;
  end

  assign imem.pc_f = pcf_q;

  assign fault_f = (pcf_q[1:0] != 2'b00) || (pcf_q < PC_RESET) || (pcf_q >= WIN_END);

  // Faulted fetches carry a NOP so garbage never reaches decode.
  always_comb begin
    ifid_ld.instr = fault_f ? NOP : imem.instr_f;
    ifid_ld.pc    = pcf_q;
    ifid_ld.pc8   = pcf_q + 32'd8;
    ifid_ld.fault = fault_f;
  end

  // Without a delay slot the word at pc_f during a redirect is wrong-path,
  // so it is replaced by a bubble.
  always_comb begin
    ifid_op = IFID_LOAD;
    if (flush)                       ifid_op = IFID_BUBBLE;
    else if (stall)                  ifid_op = IFID_HOLD;
    else if (redirect && !DELAY_SLOT) ifid_op = IFID_BUBBLE;
  end

  fetch_stage_if_id_reg u_if_id (
    .clk       (clk),
    .reset     (reset),
    .op        (ifid_op),
    .ld        (ifid_ld),
    .q         (ifid),
    .fetch_cnt (fetch_cnt)
  );

  assign instr_d = ifid.instr;
  assign pc_d    = ifid.pc;
  assign pc8_d   = ifid.pc8;
  assign fault_d = ifid.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: drives two fetch_stage instances (DELAY_SLOT=1 and 0) with
// identical control. Each cycle the expected post-edge state is pushed to a
// scoreboard queue and popped/compared after the edge.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect;
  logic [31:0] npc;

  always #5 clk = ~clk;

  fetch_stage_if if1();
  fetch_stage_if if0();

  logic [31:0] instr_d1, pc_d1, pc8_d1, cnt1;
  logic [31:0] instr_d0, pc_d0, pc8_d0, cnt0;
  logic        fault_d1, fault_d0;

  // Instruction memory: a distinct, never-zero word per address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign if1.instr_f = imem_word(if1.pc_f);
  assign if0.instr_f = imem_word(if0.pc_f);

  fetch_stage #(.PC_RESET(32'h0000_3000), .ADR_BITS(12), .DELAY_SLOT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect(redirect),
    .npc(npc), .imem(if1), .instr_d(instr_d1), .pc_d(pc_d1), .pc8_d(pc8_d1),
    .fault_d(fault_d1), .fetch_cnt(cnt1));

  fetch_stage #(.PC_RESET(32'h0000_3000), .ADR_BITS(12), .DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect(redirect),
    .npc(npc), .imem(if0), .instr_d(instr_d0), .pc_d(pc_d0), .pc8_d(pc8_d0),
    .fault_d(fault_d0), .fetch_cnt(cnt0));

  typedef struct {
    logic [31:0] pc_f;
    if_id_t      r1, r0;
    logic [31:0] c1, c0;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  if_id_t      m1, m0;
  logic [31:0] mc1, mc0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Window 0x3000..0x6FFF for PC_RESET=0x3000, ADR_BITS=12.
  function automatic logic m_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_7000);
  endfunction

  task automatic cyc(input logic r, input logic s, input logic f, input logic rd,
                     input logic [31:0] np);
    exp_t   e, g;
    if_id_t ld;
    reset = r; stall = s; flush = f; redirect = rd; npc = np;
    ld.fault = m_fault(m_pc);
    ld.instr = ld.fault ? 32'h0 : imem_word(m_pc);
    ld.pc    = m_pc;
    ld.pc8   = m_pc + 32'd8;
    e.pc_f = m_pc; e.r1 = m1; e.r0 = m0; e.c1 = mc1; e.c0 = mc0;
    if (r) begin
      e.pc_f = 32'h0000_3000; e.r1 = '0; e.r0 = '0; e.c1 = '0; e.c0 = '0;
    end else begin
      if (!s) e.pc_f = rd ? np : m_pc + 32'd4;
      if (f) begin
        e.r1 = '0; e.r0 = '0;
      end else if (!s) begin
        e.r1 = ld; e.c1 = mc1 + 32'd1;
        if (rd) e.r0 = '0;
        else begin e.r0 = ld; e.c0 = mc0 + 32'd1; end
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("pc_f1",    if1.pc_f, g.pc_f);
    chk("pc_f0",    if0.pc_f, g.pc_f);
    chk("instr_d1", instr_d1, g.r1.instr);
    chk("pc_d1",    pc_d1,    g.r1.pc);
    chk("pc8_d1",   pc8_d1,   g.r1.pc8);
    chk("fault_d1", {31'b0, fault_d1}, {31'b0, g.r1.fault});
    chk("cnt1",     cnt1,     g.c1);
    chk("instr_d0", instr_d0, g.r0.instr);
    chk("pc_d0",    pc_d0,    g.r0.pc);
    chk("pc8_d0",   pc8_d0,   g.r0.pc8);
    chk("fault_d0", {31'b0, fault_d0}, {31'b0, g.r0.fault});
    chk("cnt0",     cnt0,     g.c0);
    m_pc = g.pc_f; m1 = g.r1; m0 = g.r0; mc1 = g.c1; mc0 = g.c0;
  endtask

  initial begin
    logic        rr, ss, ff, dd;
    logic [31:0] nn;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; npc = '0;
    m_pc = '0; m1 = '0; m0 = '0; mc1 = '0; mc0 = '0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_pc", if1.pc_f, 32'h3000);
    chk("rst_cnt", cnt1, 32'h0);

    // Free run: pc 3000 -> 3004 -> 3008 -> 300C, IF/ID one cycle behind.
    cyc(0, 0, 0, 0, 0);
    chk("run_pc_d", pc_d1, 32'h3000);
    chk("run_pc8_d", pc8_d1, 32'h3008);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("run_pc", if1.pc_f, 32'h300C);
    chk("run_cnt", cnt1, 32'd3);

    // Stall two cycles: everything holds.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("stall_pc", if1.pc_f, 32'h300C);
    chk("stall_pc_d", pc_d1, 32'h3008);
    chk("stall_cnt", cnt1, 32'd3);
    cyc(0, 0, 0, 0, 0);

    // Redirect at pc_f=0x3010: delay slot loads in dut1, bubble in dut0.
    cyc(0, 0, 0, 1, 32'h3100);
    chk("redir_pc", if1.pc_f, 32'h3100);
    chk("redir_ds1_pc_d", pc_d1, 32'h3010);
    chk("redir_ds0_pc_d", pc_d0, 32'h0);
    chk("redir_ds0_instr", instr_d0, 32'h0);
    cyc(0, 0, 0, 0, 0);
    chk("target_pc_d", pc_d1, 32'h3100);

    // Redirect under stall is ignored, then re-asserted unstalled.
    cyc(0, 1, 0, 1, 32'h3200);
    chk("rs_pc_hold", if1.pc_f, 32'h3104);
    cyc(0, 0, 0, 1, 32'h3200);
    chk("rs_pc", if1.pc_f, 32'h3200);

    // Flush with stall: IF/ID zeroed, PC holds.
    cyc(0, 1, 1, 0, 0);
    chk("fs_instr", instr_d1, 32'h0);
    chk("fs_pc", if1.pc_f, 32'h3200);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Fault cases: misaligned, window end, below base, 32-bit wrap.
    cyc(0, 0, 0, 1, 32'h3002);
    cyc(0, 0, 0, 0, 0);
    chk("mis_fault", {31'b0, fault_d1}, 32'h1);
    chk("mis_instr", instr_d1, 32'h0);
    cyc(0, 0, 0, 1, 32'h7000);
    cyc(0, 0, 0, 0, 0);
    chk("end_fault", {31'b0, fault_d1}, 32'h1);
    cyc(0, 0, 0, 1, 32'h6FFC);
    cyc(0, 0, 0, 0, 0);
    chk("last_ok", {31'b0, fault_d1}, 32'h0);
    cyc(0, 0, 0, 1, 32'h2FFC);
    cyc(0, 0, 0, 0, 0);
    chk("low_fault", {31'b0, fault_d1}, 32'h1);
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_pc", if1.pc_f, 32'h0);
    cyc(0, 0, 0, 0, 0);

    // Reset mid-stream at 0x3200, with a redirect that must not survive.
    cyc(0, 0, 0, 1, 32'h3200);
    cyc(1, 0, 0, 1, 32'h3400);
    chk("mrst_pc", if1.pc_f, 32'h3000);
    chk("mrst_cnt", cnt1, 32'h0);
    cyc(0, 0, 0, 0, 0);
    chk("mrst_first", pc_d1, 32'h3000);

    // Random mix.
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 63) == 0);
      ss = ($urandom_range(0, 3) == 0);
      ff = ($urandom_range(0, 7) == 0);
      dd = ($urandom_range(0, 3) == 0);
      nn = 32'h0000_2F00 + $urandom_range(0, 32'h4200);
      if ($urandom_range(0, 7) != 0) nn[1:0] = 2'b00;
      cyc(rr, ss, ff, dd, nn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
